// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constant control vectors for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_TIMEOUT  = 2'b10
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_write;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                     idex_bubble: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0};

  // Whole front end and EX/MEM hold; only MEM/WB takes a bubble while memory is busy.
  localparam ctrl_t CTRL_FREEZE  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                     idex_bubble: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1};

  localparam ctrl_t CTRL_LOADUSE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                     idex_bubble: 1'b1, exmem_write: 1'b1, memwb_bubble: 1'b0};

  localparam ctrl_t CTRL_FLUSH   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                     idex_bubble: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait, load-use and
// taken-branch hazards, drives pipeline register controls and keeps performance counters.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 5,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             loadUse_i,
  input  logic             branchTaken_i,
  input  logic             dmemReq_i,
  input  logic             dmemReady_i,
  output logic             pcWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             EXMEMWrite_o,
  output logic             MEMWBBubble_o,
  output logic             memTimeout_o,
  output logic [CNT_W-1:0] stallCount_o,
  output logic [CNT_W-1:0] flushCount_o
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_e            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_mem_stall;
  ctrl_t             w_ctrl;

  assign w_mem_stall = dmemReq_i & ~dmemReady_i;
  assign w_wait_inc  = r_wait_cnt + WAIT_W'(1);

  // NOTE: defaulting w_ctrl before the case guarantees no latch on any path.
  always_comb begin
    w_ctrl = CTRL_DEFAULT;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall)        w_ctrl = CTRL_FREEZE;
        else if (loadUse_i)     w_ctrl = CTRL_LOADUSE;
        else if (branchTaken_i) w_ctrl = CTRL_FLUSH;
      end
      ST_MEM_WAIT: begin
        if (!dmemReady_i) w_ctrl = CTRL_FREEZE;
      end
      ST_TIMEOUT: w_ctrl = CTRL_FREEZE;
      default:    w_ctrl = CTRL_DEFAULT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (dmemReady_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else begin
            // The counter tracks frozen cycles so far; hitting MAX_WAIT means the limit is spent.
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == MAX_WAIT_C) begin
              r_state       <= ST_TIMEOUT;
              r_mem_timeout <= 1'b1;
            end
          end
        end
        ST_TIMEOUT: begin
          r_state       <= ST_TIMEOUT;
          r_mem_timeout <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign pcWrite_o     = w_ctrl.pc_write;
  assign IFIDWrite_o   = w_ctrl.ifid_write;
  assign IFIDFlush_o   = w_ctrl.ifid_flush;
  assign IDEXBubble_o  = w_ctrl.idex_bubble;
  assign EXMEMWrite_o  = w_ctrl.exmem_write;
  assign MEMWBBubble_o = w_ctrl.memwb_bubble;
  assign memTimeout_o  = r_mem_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .i_inc   (~w_ctrl.pc_write),
    .o_count (stallCount_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .i_inc   (w_ctrl.ifid_flush),
    .o_count (flushCount_o)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (MAX_WAIT=4, CNT_W=4).
module tb_pipeline_stall_ctrl;

  // Control vector order: {pcWrite, IFIDWrite, IFIDFlush, IDEXBubble, EXMEMWrite, MEMWBBubble}
  localparam logic [5:0] DEF = 6'b110010;
  localparam logic [5:0] FRZ = 6'b000001;
  localparam logic [5:0] LU  = 6'b000110;
  localparam logic [5:0] FL  = 6'b111010;

  logic       clk = 1'b0;
  logic       rst, load_use, branch, dmem_req, dmem_ready;
  logic       pc_w, ifid_w, ifid_f, idex_b, exmem_w, memwb_b, timeout;
  logic [3:0] stall_cnt, flush_cnt;
  logic [5:0] ctrl;
  int         total = 0;
  int         bad   = 0;

  assign ctrl = {pc_w, ifid_w, ifid_f, idex_b, exmem_w, memwb_b};

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MAX_WAIT(4), .WAIT_W(5), .CNT_W(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .loadUse_i     (load_use),
    .branchTaken_i (branch),
    .dmemReq_i     (dmem_req),
    .dmemReady_i   (dmem_ready),
    .pcWrite_o     (pc_w),
    .IFIDWrite_o   (ifid_w),
    .IFIDFlush_o   (ifid_f),
    .IDEXBubble_o  (idex_b),
    .EXMEMWrite_o  (exmem_w),
    .MEMWBBubble_o (memwb_b),
    .memTimeout_o  (timeout),
    .stallCount_o  (stall_cnt),
    .flushCount_o  (flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_use = 1'b0; branch = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    load_use = 1'b1;
    tick();
    tick();
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
    rst = 1'b1;
    #1;
    total++; if (ctrl !== LU) begin bad++; $display("FAIL rst_release_ctrl got=%b exp=%b", ctrl, LU); end
    tick();
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL rst_release_stall got=%0d exp=1", stall_cnt); end
    load_use = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    load_use = 1'b1;
    #1;
    total++; if (ctrl !== LU) begin bad++; $display("FAIL lu_ctrl got=%b exp=%b", ctrl, LU); end
    tick();
    load_use = 1'b0;
    #1;
    total++; if (ctrl !== DEF) begin bad++; $display("FAIL lu_after_ctrl got=%b exp=%b", ctrl, DEF); end
    tick();
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    total++; if (flush_cnt !== 4'd0) begin bad++; $display("FAIL lu_flush_cnt got=%0d exp=0", flush_cnt); end
  endtask

  task automatic test_branch_load_use();
    do_reset();
    load_use = 1'b1; branch = 1'b1;
    #1;
    total++; if (ctrl !== LU) begin bad++; $display("FAIL br_lu_ctrl got=%b exp=%b", ctrl, LU); end
    tick();
    load_use = 1'b0;
    #1;
    total++; if (ctrl !== FL) begin bad++; $display("FAIL br_flush_ctrl got=%b exp=%b", ctrl, FL); end
    tick();
    branch = 1'b0;
    #1;
    total++; if (ctrl !== DEF) begin bad++; $display("FAIL br_idle_ctrl got=%b exp=%b", ctrl, DEF); end
    total++; if (flush_cnt !== 4'd1) begin bad++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt); end
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL br_stall_cnt got=%0d exp=1", stall_cnt); end
    // A memory request that completes immediately must not stall a taken branch.
    dmem_req = 1'b1; dmem_ready = 1'b1; branch = 1'b1;
    #1;
    total++; if (ctrl !== FL) begin bad++; $display("FAIL br_mem_hit_ctrl got=%b exp=%b", ctrl, FL); end
    tick();
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin load_use = 1'b1; branch = 1'b1; end
      #1;
      total++; if (ctrl !== FRZ) begin bad++; $display("FAIL mw_freeze_ctrl cyc=%0d got=%b exp=%b", i, ctrl, FRZ); end
      tick();
    end
    load_use = 1'b0; branch = 1'b0;
    dmem_ready = 1'b1;
    #1;
    total++; if (ctrl !== DEF) begin bad++; $display("FAIL mw_ready_ctrl got=%b exp=%b", ctrl, DEF); end
    tick();
    clear_inputs();
    #1;
    total++; if (stall_cnt !== 4'd3) begin bad++; $display("FAIL mw_stall_cnt got=%0d exp=3", stall_cnt); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL mw_timeout got=%b exp=0", timeout); end
    load_use = 1'b1;
    #1;
    total++; if (ctrl !== LU) begin bad++; $display("FAIL mw_back_in_run got=%b exp=%b", ctrl, LU); end
    tick();
    load_use = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctrl !== FRZ) begin bad++; $display("FAIL to_freeze_ctrl cyc=%0d got=%b exp=%b", i, ctrl, FRZ); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early_flag cyc=%0d got=%b exp=0", i, timeout); end
      tick();
    end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag_set got=%b exp=1", timeout); end
    dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (ctrl !== FRZ) begin bad++; $display("FAIL to_hold_ctrl cyc=%0d got=%b exp=%b", i, ctrl, FRZ); end
      tick();
      total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky cyc=%0d got=%b exp=1", i, timeout); end
    end
    total++; if (stall_cnt !== 4'd6) begin bad++; $display("FAIL to_stall_cnt got=%0d exp=6", stall_cnt); end
    rst = 1'b0;
    tick();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_reset_flag got=%b exp=0", timeout); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL to_reset_cnt got=%0d exp=0", stall_cnt); end
    rst = 1'b1;
    clear_inputs();
    #1;
    total++; if (ctrl !== DEF) begin bad++; $display("FAIL to_run_ctrl got=%b exp=%b", ctrl, DEF); end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    do_reset();
    load_use = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt = (i > 15) ? 4'd15 : 4'(i);
      total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL sat_stall_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, exp_cnt); end
    end
    load_use = 1'b0;
    tick();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
